// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch front end.
//   fetch_state_e : RUN issues requests normally; FLUSH discards the stale
//                   responses still in flight after a redirect.
//   INSTR_BYTES   : byte stride between consecutive instruction words.
//   fetch_entry_t : instruction word plus its PC at the default 32/32 widths.
//                   Modules built with other widths declare a matching local
//                   struct and hand it to fetch_queue as a type parameter.
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO, first-word-fall-through: the oldest entry is always
// visible on head. Used both for the instruction queue and for the PC-tag FIFO.
//
// Parameters:
//   entry_t : stored element type (packed)
//   DEPTH   : number of entries, power of two, >= 2
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears storage too)
//   push       : write push_data at the tail (ignored when full without pop)
//   push_data  : element to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard all entries; dominates push and pop
//   head       : oldest entry
//   count      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter type entry_t = fetch_entry_t,
   parameter int  DEPTH   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  entry_t                   push_data,
   input  logic                     pop,
   input  logic                     flush,
   output entry_t                   head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr_reg;
   logic [PW-1:0]   wr_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [DEPTH-1:0] slot_we;
   logic            empty;
   logic            full;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   // A push into a full queue is allowed when the head leaves the same cycle.
   assign do_push = push && !flush && (!full || do_pop);

   // One write enable per storage slot.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
         assign slot_we[gi] = do_push && (wr_ptr_reg == PW'(gi));
      end
   endgenerate

   // Storage is reset so head reads as zero while the queue is empty after reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) begin
            mem[i] <= '0;
         end else if (slot_we[i]) begin
            mem[i] <= push_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;

endmodule : fetch_queue

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Front-end stage feeding instruction_decoder. Holds the PC, issues word
// requests to instruction memory (in-order, variable-latency responses),
// buffers returned words with their PCs and hands them to the decoder.
// Redirects flush the buffered words and discard responses still in flight.
//
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched and
// perf_flush_cycles saturating 32-bit counters.
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   imem_req_valid/ready/addr  : request channel to instruction memory
//   imem_resp_valid/data       : in-order response channel
//   redirect_valid/pc          : single-cycle control-flow redirect
//   instr_valid/ready/out/pc   : instruction channel to the decoder
//   perf_fetched               : (macro only) decoder handshakes
//   perf_flush_cycles          : (macro only) cycles in FLUSH or redirecting
// -----------------------------------------------------------------------------
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                    QUEUE_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [ADDR_WIDTH-1:0]  imem_req_addr,
   input  logic                   imem_resp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_resp_data,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [ADDR_WIDTH-1:0]  instr_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            perf_fetched,
   output logic [31:0]            perf_flush_cycles
`endif
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [ADDR_WIDTH-1:0]  pc;
   } entry_t;

   fetch_state_e          state_reg;
   fetch_state_e          state_next;
   logic [ADDR_WIDTH-1:0] pc_reg;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [CW-1:0]         drop_cnt_reg;
   logic [CW-1:0]         drop_cnt_next;

   logic [ADDR_WIDTH-1:0] redirect_target;
   logic [ADDR_WIDTH-1:0] tag_head;
   logic [CW-1:0]         queue_count;
   logic [CW-1:0]         outstanding;
   logic [CW-1:0]         outstanding_left;
   logic [CW:0]           credits_used;
   logic                  req_fire;
   logic                  resp_accept;
   logic                  queue_push;
   logic                  queue_pop;
   entry_t                queue_push_data;
   entry_t                queue_head;

   assign redirect_target = redirect_pc & ALIGN_MASK;

   // Every buffered word and every request in flight holds one queue slot,
   // so the queue can never overflow.
   assign credits_used = {1'b0, queue_count} + {1'b0, outstanding};

   assign imem_req_valid = !rst && (state_reg == RUN) && !redirect_valid &&
                           (credits_used < (CW + 1)'(QUEUE_DEPTH));
   assign imem_req_addr  = pc_reg;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses with nothing outstanding are protocol errors and are ignored.
   assign resp_accept      = (state_reg == RUN) && imem_resp_valid && (outstanding != '0);
   assign outstanding_left = outstanding - {{(CW - 1){1'b0}}, resp_accept};

   // A response arriving in the redirect cycle is consumed but discarded.
   assign queue_push      = resp_accept && !redirect_valid;
   assign queue_pop       = instr_valid && instr_ready;
   assign queue_push_data = '{instr: imem_resp_data, pc: tag_head};

   // PC-tag FIFO: one tag per issued request, so its occupancy is the
   // outstanding-request count. A redirect empties it; stale responses are
   // then tracked by drop_cnt alone.
   fetch_queue #(
      .entry_t (logic [ADDR_WIDTH-1:0]),
      .DEPTH   (QUEUE_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_fire),
      .push_data (pc_reg),
      .pop       (resp_accept),
      .flush     (redirect_valid),
      .head      (tag_head),
      .count     (outstanding)
   );

   fetch_queue #(
      .entry_t (entry_t),
      .DEPTH   (QUEUE_DEPTH)
   ) u_instr_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (queue_push),
      .push_data (queue_push_data),
      .pop       (queue_pop),
      .flush     (redirect_valid),
      .head      (queue_head),
      .count     (queue_count)
   );

   assign instr_valid = (queue_count != '0);
   assign instr_out   = queue_head.instr;
   assign instr_pc    = queue_head.pc;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= RUN;
         pc_reg       <= RESET_PC;
         drop_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      drop_cnt_next = drop_cnt_reg;
      case (state_reg)
         RUN: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
               if (outstanding_left != '0) begin
                  drop_cnt_next = outstanding_left;
                  state_next    = FLUSH;
               end
            end else if (req_fire) begin
               pc_next = pc_reg + PC_STEP;
            end
         end
         FLUSH: begin
            // A redirect here only moves the target; the stale count stands.
            if (redirect_valid) begin
               pc_next = redirect_target;
            end
            if (imem_resp_valid) begin
               drop_cnt_next = drop_cnt_reg - CW'(1);
               if (drop_cnt_reg == CW'(1)) begin
                  state_next = RUN;
               end
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

`ifdef FETCH_PERF_CNT_EN
   // ------------------------------------------------ saturating counters
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched      <= '0;
         perf_flush_cycles <= '0;
      end else begin
         if (queue_pop && (perf_fetched != '1)) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (((state_reg == FLUSH) || redirect_valid) && (perf_flush_cycles != '1)) begin
            perf_flush_cycles <= perf_flush_cycles + 32'd1;
         end
      end
   end
`endif

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Randomized bench with a scoreboard. The reference model is the program-order
// view: after reset or a redirect to T, the decoder must see T, T+4, T+8 ...
// each with the memory word of that address, and memory must see requests
// for exactly those addresses in order. The memory model returns words in
// order with a configurable latency.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam int          IW     = 32;
   localparam int          AW     = 32;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic          clk;
   logic          rst;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [AW-1:0] imem_req_addr;
   logic          imem_resp_valid;
   logic [IW-1:0] imem_resp_data;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic [IW-1:0] instr_out;
   logic [AW-1:0] instr_pc;

   instruction_fetch #(
      .INSTR_WIDTH (IW),
      .ADDR_WIDTH  (AW),
      .RESET_PC    (RST_PC),
      .QUEUE_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr_out       (instr_out),
      .instr_pc        (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // ------------------------------------------------------------ memory model
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   int          cyc      = 0;
   int          n_req    = 0;
   int          n_deliv  = 0;
   int          p_ready  = 100;
   int          p_resp   = 100;
   int          lat_min  = 1;
   int          lat_max  = 1;
   int          p_dec    = 100;
   int          p_redir  = 0;
   logic [31:0] exp_req_pc = RST_PC;

   // One clock cycle: sample the handshakes at the falling edge, then drive
   // fresh inputs just after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (rst) begin
         pend.delete();
         exp_req_pc = RST_PC;
      end else begin
         if (redirect_valid) begin
            chk("req_in_redirect", {31'b0, imem_req_valid}, 32'h0);
         end
         if (imem_resp_valid && pend.size() > 0) begin
            pend.delete(0);
         end
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req_pc);
            exp_req_pc = exp_req_pc + 32'd4;
            pend.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            n_req++;
            chk("credit_limit", {31'b0, pend.size() <= DEPTH}, 32'h1);
         end
         if (redirect_valid) begin
            exp_req_pc = redirect_pc & ~32'h3;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_req_ready = ($urandom_range(99) < p_ready);
      if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < p_resp) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      instr_ready = ($urandom_range(99) < p_dec);
      if (!rst && $urandom_range(99) < p_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = $urandom & 32'h0000_FFFF;
      end else begin
         redirect_valid = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      #1;
   endtask

   // ------------------------------------------------------- decoder monitor
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] fill_pc = RST_PC;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            fill_pc = RST_PC;
         end else begin
            if (instr_valid && instr_ready) begin
               e = exp_q.pop_front();
               chk("instr_pc", instr_pc, e.pc);
               chk("instr_out", instr_out, e.instr);
               n_deliv++;
            end
            if (redirect_valid) begin
               exp_q.delete();
               fill_pc = redirect_pc & ~32'h3;
            end
         end
         while (exp_q.size() < 8) begin
            exp_q.push_back('{fill_pc, mem_word(fill_pc)});
            fill_pc = fill_pc + 32'd4;
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   initial begin
      int base;
      int k;
      rst             = 1'b1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      instr_ready     = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_req_valid",   {31'b0, imem_req_valid}, 32'h0);
      chk("rst_instr_valid", {31'b0, instr_valid},    32'h0);
      chk("rst_req_addr",    imem_req_addr,           RST_PC);
      chk("rst_instr_out",   instr_out,               32'h0);
      chk("rst_instr_pc",    instr_pc,                32'h0);
      rst = 1'b0;
      #1;

      // Streaming with a 1-cycle memory
      base = n_deliv;
      repeat (20) tick();
      chk("stream_progress", {31'b0, (n_deliv - base) >= 8}, 32'h1);

      // Decoder stall: queue fills, exactly two requests, head held
      p_dec = 0;
      do_reset();
      base = n_req;
      repeat (10) tick();
      chk("stall_req_count",   n_req - base,            32'd2);
      chk("stall_instr_valid", {31'b0, instr_valid},    32'h1);
      chk("stall_instr_pc",    instr_pc,                32'h0);
      chk("stall_instr_out",   instr_out,               mem_word(32'h0));
      chk("stall_req_valid",   {31'b0, imem_req_valid}, 32'h0);
      p_dec = 100;
      repeat (10) tick();

      // Memory not ready: address holds
      p_ready = 0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         chk("hold_req_valid", {31'b0, imem_req_valid}, 32'h1);
         chk("hold_req_addr",  imem_req_addr,           32'h0);
         tick();
      end
      p_ready = 100;
      repeat (8) tick();

      // Redirect with two requests outstanding (3-cycle memory)
      lat_min = 3;
      lat_max = 3;
      do_reset();
      k = 0;
      while (pend.size() != 2 && k < 20) begin
         tick();
         k++;
      end
      chk("two_outstanding", pend.size(), 32'd2);
      base = n_deliv;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      chk("flush_no_req", {31'b0, imem_req_valid}, 32'h0);
      repeat (20) tick();
      chk("after_flush_progress", {31'b0, (n_deliv - base) > 0}, 32'h1);

      // Redirect with nothing outstanding and a full queue
      lat_min = 1;
      lat_max = 1;
      p_dec   = 0;
      do_reset();
      repeat (6) tick();
      chk("full_instr_valid", {31'b0, instr_valid},    32'h1);
      chk("full_req_valid",   {31'b0, imem_req_valid}, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      p_dec          = 100;
      tick();
      chk("redir_instr_valid", {31'b0, instr_valid},    32'h0);
      chk("redir_req_valid",   {31'b0, imem_req_valid}, 32'h1);
      chk("redir_req_addr",    imem_req_addr,           32'h0000_0040);
      repeat (10) tick();

      // PC wrap at the top of the address space
      base = n_deliv;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      repeat (15) tick();
      chk("wrap_progress", {31'b0, (n_deliv - base) >= 2}, 32'h1);

      // Reset while flushing
      lat_min = 4;
      lat_max = 4;
      k = 0;
      while (pend.size() != 2 && k < 20) begin
         tick();
         k++;
      end
      chk("two_outstanding_b", pend.size(), 32'd2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick();
      chk("flush_b_no_req", {31'b0, imem_req_valid}, 32'h0);
      rst = 1'b1;
      tick();
      chk("rst_flush_req_addr",    imem_req_addr,           RST_PC);
      chk("rst_flush_instr_valid", {31'b0, instr_valid},    32'h0);
      rst = 1'b0;
      #1;
      chk("rst_flush_run",  {31'b0, imem_req_valid}, 32'h1);
      chk("rst_flush_addr", imem_req_addr,           RST_PC);
      repeat (20) tick();

      // Randomized traffic with random redirects
      lat_min = 1;
      lat_max = 4;
      p_ready = 70;
      p_resp  = 70;
      p_dec   = 70;
      p_redir = 3;
      base    = n_deliv;
      repeat (3000) tick();
      chk("random_progress", {31'b0, (n_deliv - base) > 200}, 32'h1);
      p_redir = 0;
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end stage directly upstream of instruction_decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned instructions in a small queue and presents them with their PC to the decoder over a valid/ready handshake.
- Accepts redirects from branch/jump resolution and discards stale fetches.

Parameters:
- INSTR_WIDTH, 32, instruction word width in bits.
- ADDR_WIDTH, 32, PC / memory byte-address width.
- RESET_PC, 0, PC value after reset; must be word aligned.
- QUEUE_DEPTH, 2, instruction queue entries and maximum outstanding requests; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  ADDR_WIDTH  byte address of requested word.
- imem_resp_valid  input  1  response word valid; responses return in request order, never before the cycle after acceptance.
- imem_resp_data  input  INSTR_WIDTH  returned instruction word.
- redirect_valid  input  1  control-flow redirect, single-cycle pulse.
- redirect_pc  input  ADDR_WIDTH  redirect target; low two bits ignored (treated as 0).
- instr_valid  output  1  instr_out/instr_pc valid to decoder.
- instr_ready  input  1  decoder consumes the head entry.
- instr_out  output  INSTR_WIDTH  instruction word to decoder instr_in.
- instr_pc  output  ADDR_WIDTH  PC of instr_out.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC; queue empty; outstanding=0; state=RUN.
  - imem_req_valid=0, instr_valid=0; imem_req_addr=RESET_PC; instr_out=0, instr_pc=0.
  - In-flight responses are lost; memory must also be reset.
- Credit rule:
  - imem_req_valid=1 only in RUN, when no redirect_valid this cycle, and when queue_count + outstanding < QUEUE_DEPTH.
  - imem_req_addr=pc. On request handshake: pc += 4 (wraps modulo 2^ADDR_WIDTH) and outstanding++.
- RUN:
  - A response with outstanding>0 is written to the queue tail with its PC (PC FIFO tracks issued addresses); outstanding--.
  - A response with outstanding=0 is a protocol error; it is ignored and the queue is unchanged.
- Queue: head drives instr_out/instr_pc, valid whenever non-empty. A pop occurs on instr_valid & instr_ready. A simultaneous push and pop on a full queue is legal (credit rule prevents overflow).
- Latency: request accept at cycle N, response at N+k → instr_valid at N+k+1 (registered queue); no combinational path from imem_resp to instr_valid.
- Redirect (highest priority, any state):
  - Flush the queue (instr_valid=0 next cycle); pc=redirect_pc.
  - Any request handshaking in the redirect cycle is suppressed (req_valid forced 0).
  - If outstanding (after a same-cycle response) > 0: drop_cnt=outstanding, state=FLUSH. Else stay in RUN and issue from redirect_pc next cycle.
- FLUSH:
  - No requests; each response decrements drop_cnt and is discarded.
  - At drop_cnt reaching 0: state=RUN, issue from redirect_pc the following cycle.
  - A new redirect in FLUSH updates pc only; drop_cnt is unchanged.
- Decoder stall (instr_ready=0) holds the head stable; the queue fills, then requests stop via credits.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32-bit, increments per instr_valid&instr_ready) and perf_flush_cycles (32-bit, increments each cycle in FLUSH or a redirect cycle). Both are cleared by rst and saturate at all-ones.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: fetch_state_e {RUN, FLUSH}; localparam INSTR_BYTES=4; typedef fetch_entry_t {instr, pc}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push/pop/flush, count output, depth QUEUE_DEPTH.
- Top-level holds the FSM, PC, outstanding/drop counters, and PC-tag FIFO.

Test Plan:
- Reset then 1-cycle memory, instr_ready=1 → requests 0x0,0x4,0x8…; instr_pc 0x0,0x4 on consecutive cycles, instr_out equals memory words.
- instr_ready=0 with 1-cycle memory → exactly 2 requests issued, instr_valid held with instr_pc=0x0, req_valid=0 until a pop.
- imem_req_ready low 3 cycles → imem_req_addr stable at 0x0; pc advances only on the handshake.
- 2 outstanding (3-cycle latency), redirect to 0x100 → FLUSH, both stale responses dropped, next request addr 0x100, first instr_pc 0x100.
- Redirect with outstanding=0 and queue full → instr_valid=0 next cycle, request to redirect_pc issued the cycle after.
- pc=0xFFFFFFFC, ADDR_WIDTH=32 → next request addr 0x00000000; rst asserted mid-FLUSH → state RUN, addr RESET_PC.
